// File: rtl/rand_sampler_pkg.sv
// rand_sampler_pkg: shared state encoding, request modes and counter width for rand_sampler.
package rand_sampler_pkg;
  typedef enum logic [1:0] {IDLE, MASK, DRAW, RESP} state_e;
  localparam logic MODE_BERN = 1'b0;
  localparam logic MODE_BOUND = 1'b1;
  localparam int TRIES_W = 4;
endpackage

// File: rtl/rand_mask_gen.sv
// rand_mask_gen: smallest all-ones mask covering N-1, so masked draws land in [0, 2N).
module rand_mask_gen (
  input  logic [31:0] n_i,
  output logic [31:0] mask_o
);
  always_comb begin
    mask_o = n_i - 32'd1;
    mask_o = mask_o | (mask_o >> 1);
    mask_o = mask_o | (mask_o >> 2);
    mask_o = mask_o | (mask_o >> 4);
    mask_o = mask_o | (mask_o >> 8);
    mask_o = mask_o | (mask_o >> 16);
  end
endmodule

// File: rtl/rand_sampler.sv
// rand_sampler: turns PRNG words into Bernoulli decisions or bounded integers,
// using masked rejection sampling with a deterministic fallback after MAX_TRIES draws.
module rand_sampler
  import rand_sampler_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        rnd_data,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mode,
  input  logic [31:0]        req_arg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic               rsp_fallback,
  output logic [TRIES_W-1:0] rsp_tries
);
  localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);
  state_e state_q, state_d;
  logic mode_q, mode_d, err_q, err_d, fb_q, fb_d;
  logic [31:0] arg_q, arg_d, mask_q, mask_d, data_q, data_d, mask_w, cand;
  logic [TRIES_W-1:0] tries_q, tries_d, tries_inc;
  rand_mask_gen u_mask (.n_i(arg_q), .mask_o(mask_w));
  assign cand = rnd_data & mask_q;
  assign tries_inc = tries_q + TRIES_W'(1);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    arg_d = arg_q;
    mask_d = mask_q;
    data_d = data_q;
    err_d = err_q;
    fb_d = fb_q;
    tries_d = tries_q;
    case (state_q)
      IDLE: if (req_valid) begin
        mode_d = req_mode;
        arg_d = req_arg;
        tries_d = '0;
        data_d = '0;
        fb_d = 1'b0;
        err_d = req_mode == MODE_BOUND && req_arg == '0;
        state_d = req_mode == MODE_BERN ? DRAW : req_arg == '0 ? RESP : MASK;
      end
      MASK: begin
        mask_d = mask_w;
        state_d = DRAW;
      end
      DRAW: if (rnd_valid) begin
        if (mode_q == MODE_BERN) begin
          data_d = {31'b0, rnd_data < arg_q};
          state_d = RESP;
        end else if (cand < arg_q) begin
          data_d = cand;
          state_d = RESP;
        end else begin
          tries_d = tries_inc;
          // mask < 2N, so cand - N lands in [0,N) without underflow
          if (tries_inc == MAX_T) begin
            data_d = cand - arg_q;
            fb_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= MODE_BERN;
      arg_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      fb_q <= 1'b0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      arg_q <= arg_d;
      mask_q <= mask_d;
      data_q <= data_d;
      err_q <= err_d;
      fb_q <= fb_d;
      tries_q <= tries_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rnd_ready = state_q == DRAW;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = data_q;
  assign rsp_err = err_q;
  assign rsp_fallback = fb_q;
  assign rsp_tries = tries_q;
endmodule

// File: tb/tb_rand_sampler.sv
// tb_rand_sampler: directed and randomized requests checked against a behavioural sampling model.
module tb_rand_sampler;
  localparam int MT = 8;
  typedef logic [31:0] wq_t[$];
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] rnd_data = '0, req_arg = '0, rsp_data;
  logic rnd_valid = 1'b0, rnd_ready, req_valid = 1'b0, req_ready, req_mode = 1'b0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_fallback;
  logic [3:0] rsp_tries;
  int passed = 0, total = 0;
  logic [31:0] o_data;
  logic o_err, o_fb, o_rr;
  logic [3:0] o_tries;
  int o_lat, o_used;
  wq_t q;

  rand_sampler #(.MAX_TRIES(MT)) dut (
    .clk(clk), .rst_n(rst_n), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_arg(req_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_fallback(rsp_fallback), .rsp_tries(rsp_tries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic wq_t pad(input wq_t w);
    while (w.size() < MT + 2) w.push_back($urandom);
    return w;
  endfunction

  // Reference: bounded draws use the smallest 2^k-1 mask that covers N-1.
  function automatic void model(input bit mode, input logic [31:0] a, input wq_t w,
      output logic [31:0] d, output logic e, output logic f, output logic [3:0] t, output int u);
    longint unsigned m = 0;
    logic [31:0] c;
    d = 0; e = 0; f = 0; t = 0; u = 0;
    if (!mode) begin
      d = (w[0] < a) ? 1 : 0;
      u = 1;
      return;
    end
    if (a == 0) begin
      e = 1;
      return;
    end
    while (m < longint'(a) - 1) m = m * 2 + 1;
    for (int i = 0; i < MT; i++) begin
      c = w[i] & m[31:0];
      if (c < a) begin
        d = c; t = 4'(i); u = i + 1;
        return;
      end
    end
    c = w[MT-1] & m[31:0];
    d = c - a; f = 1; t = 4'(MT); u = MT;
  endfunction

  task automatic run(input bit mode, input logic [31:0] arg, input wq_t w, input bit gaps, input int bp);
    int idx = 0, n;
    bit fire = 0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_mode = mode; req_arg = arg;
    @(posedge clk);
    #1 req_valid = 0;
    n = 1; o_rr = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      if (!rnd_valid || fire) begin
        if (idx < w.size() && (!gaps || $urandom_range(3) != 0)) begin
          rnd_valid = 1; rnd_data = w[idx];
        end else rnd_valid = 0;
      end
      fire = rnd_valid && rnd_ready;
      if (rnd_ready) o_rr = 1;
      @(posedge clk);
      n++;
      if (fire) idx++;
      @(negedge clk);
    end
    chk("rsp_timeout", rsp_valid, 1);
    o_lat = n; o_used = idx;
    o_data = rsp_data; o_err = rsp_err; o_fb = rsp_fallback; o_tries = rsp_tries;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_data", rsp_data, o_data);
      chk("hold_ctl", {rsp_valid, rnd_ready, req_ready, rsp_err, rsp_fallback, rsp_tries},
          {1'b1, 1'b0, 1'b0, o_err, o_fb, o_tries});
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0; rnd_valid = 0;
  endtask

  task automatic check_req(input string tag, input bit mode, input logic [31:0] arg, input wq_t w,
      input bit gaps, input int bp, input bit lat);
    logic [31:0] d;
    logic e, f;
    logic [3:0] t;
    int u;
    model(mode, arg, w, d, e, f, t, u);
    run(mode, arg, w, gaps, bp);
    chk({tag, ".data"}, o_data, d);
    chk({tag, ".err"}, o_err, e);
    chk({tag, ".fallback"}, o_fb, f);
    chk({tag, ".tries"}, o_tries, t);
    chk({tag, ".used"}, o_used, u);
    if (e) chk({tag, ".no_rnd_ready"}, o_rr, 0);
    if (lat) chk({tag, ".latency"}, o_lat, !mode ? 2 : e ? 1 : 2 + u);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ctl", {rsp_valid, rnd_ready, req_ready, rsp_err, rsp_fallback, rsp_tries}, 9'b001000000);
    chk("rst.data", rsp_data, 0);
    rst_n = 1;
    check_req("bern_lt", 0, 32'h80000000, '{32'h7FFFFFFF}, 0, 0, 1);
    check_req("bern_eq", 0, 32'h80000000, '{32'h80000000}, 0, 0, 1);
    check_req("bern_t0", 0, 32'h0, '{32'h0}, 0, 0, 1);
    check_req("bern_tmax_hit", 0, 32'hFFFFFFFF, '{32'hFFFFFFFF}, 0, 0, 1);
    check_req("bern_tmax", 0, 32'hFFFFFFFF, '{32'hFFFFFFFE}, 0, 0, 1);
    chk("dir.n10", 32'(1), 1);
    total--; passed--;
    check_req("n10", 1, 32'd10, pad('{32'hC, 32'h17}), 0, 0, 1);
    chk("n10.value", o_data, 7);
    check_req("fallback", 1, 32'd9, '{32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF}, 0, 0, 1);
    chk("fallback.value", o_data, 6);
    check_req("n0", 1, 32'd0, pad('{32'h5}), 0, 0, 1);
    check_req("n1", 1, 32'd1, pad('{}), 0, 0, 1);
    check_req("n_big", 1, 32'h80000001, pad('{32'hFFFFFFFF, 32'h80000000}), 0, 0, 1);
    chk("n_big.value", o_data, 32'h80000000);
    check_req("backpressure", 1, 32'd10, pad('{32'h3}), 0, 20, 1);
    @(negedge clk);
    req_valid = 1; req_mode = 1; req_arg = 32'd9;
    @(posedge clk);
    #1 req_valid = 0; rnd_valid = 1; rnd_data = 32'hF;
    repeat (3) @(negedge clk);
    chk("mid_draw.rnd_ready", rnd_ready, 1);
    rst_n = 0;
    #1;
    chk("mid_rst.ctl", {rsp_valid, rnd_ready, req_ready, rsp_err, rsp_fallback, rsp_tries}, 9'b001000000);
    chk("mid_rst.data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1; rnd_valid = 0;
    check_req("after_rst", 1, 32'd10, pad('{32'hC, 32'h17}), 0, 0, 1);
    for (int k = 0; k < 60; k++) begin
      bit mode = 1'($urandom_range(1));
      int sel = $urandom_range(7);
      logic [31:0] arg;
      wq_t w;
      if (!mode) arg = sel == 0 ? 32'h0 : sel == 1 ? 32'hFFFFFFFF : $urandom;
      else arg = sel == 0 ? 32'h0 : sel < 4 ? 32'($urandom_range(1, 40)) :
                 sel < 6 ? (32'h1 << $urandom_range(0, 31)) + 32'h1 : $urandom;
      for (int i = 0; i < MT + 2; i++) w.push_back($urandom_range(1) ? $urandom : 32'($urandom_range(0, 63)));
      check_req("rand", mode, arg, w, 1, $urandom_range(0, 3), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
